fighter_command_fsm: RTL

Per-player action state machine that consumes the 7-bit controller command word (bit0 center, bit1 left, bit2 right, bit3 up, bit4 down, bit5 attack, bit6 parry) and turns it into fighter behaviour: horizontal position, pose, attack pulse and parry window. It sits between the controller input block and the game-logic and sprite renderer. It advances once per video frame, and timed actions and cooldowns are counted in frames.

---
 rtl/fighter_command_fsm.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fighter_command_fsm.sv
// fighter_command_fsm
// Per-player action state machine. Once per video frame it turns the
// controller command word into fighter behaviour: horizontal position,
// pose, a one-clock attack pulse and a parry window. Timed actions and
// their cooldowns are counted in frames.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   frame_tick   one-clk pulse per video frame; state advances only then
//   cmd[6:0]     {parry, attack, down, up, right, left, center}
//   x_pos[9:0]   fighter x position
//   pose[2:0]    0 IDLE, 1 WALK, 2 JUMP, 3 CROUCH, 4 ATTACK, 5 PARRY
//   facing_left  last horizontal direction moved
//   attack_hit   one-clk pulse coincident with the first ATTACK cycle
//   parry_active high while pose is PARRY
//   busy         high in JUMP, ATTACK or PARRY
module fighter_command_fsm #(
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 600,
  parameter int X_START         = 100,
  parameter int STEP            = 4,
  parameter int JUMP_FRAMES     = 24,
  parameter int ATTACK_FRAMES   = 12,
  parameter int ATTACK_COOLDOWN = 20,
  parameter int PARRY_FRAMES    = 8,
  parameter int PARRY_COOLDOWN  = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [6:0] cmd,
  output logic [9:0] x_pos,
  output logic [2:0] pose,
  output logic       facing_left,
  output logic       attack_hit,
  output logic       parry_active,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WALK   = 3'd1;
  localparam logic [2:0] S_JUMP   = 3'd2;
  localparam logic [2:0] S_CROUCH = 3'd3;
  localparam logic [2:0] S_ATTACK = 3'd4;
  localparam logic [2:0] S_PARRY  = 3'd5;

  localparam logic [10:0] X_MIN_W   = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [9:0]  X_MIN_X   = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_X   = 10'(X_MAX);
  localparam logic [9:0]  STEP_X    = 10'(STEP);
  localparam logic [9:0]  X_START_X = 10'(X_START);
  localparam logic [5:0]  JUMP_T    = 6'(JUMP_FRAMES);
  localparam logic [5:0]  ATTACK_T  = 6'(ATTACK_FRAMES);
  localparam logic [5:0]  ATTACK_CD = 6'(ATTACK_COOLDOWN);
  localparam logic [5:0]  PARRY_T   = 6'(PARRY_FRAMES);
  localparam logic [5:0]  PARRY_CD  = 6'(PARRY_COOLDOWN);

  logic [2:0] state, state_n;
  logic [5:0] timer, timer_n;
  logic [5:0] attack_cd, attack_cd_n;
  logic [5:0] parry_cd, parry_cd_n;
  logic [9:0] x_n, x_left, x_right;
  logic       facing_n, hit_n;
  logic       go_left, go_right, go_up, go_down;
  logic       attack_ready, parry_ready;
  logic       unused_center;

  // The center button has no action for this fighter.
  assign unused_center = cmd[0];

  // Only the highest-priority direction is honoured: left > right > up > down.
  assign go_left  = cmd[1];
  assign go_right = !cmd[1] && cmd[2];
  assign go_up    = !cmd[1] && !cmd[2] && cmd[3];
  assign go_down  = !cmd[1] && !cmd[2] && !cmd[3] && cmd[4];

  // Comparisons use an 11-bit view so neither edge can wrap around.
  assign x_left  = ({1'b0, x_pos} < X_MIN_W + STEP_W) ? X_MIN_X : x_pos - STEP_X;
  assign x_right = ({1'b0, x_pos} + STEP_W > X_MAX_W) ? X_MAX_X : x_pos + STEP_X;

  // The cooldown counter is decremented on the same tick it is tested, so a
  // value of 1 means the cooldown expires on this very tick. This makes a
  // cooldown of N frames accept the action exactly N ticks after exit, and a
  // cooldown of 0 accept it on the tick right after exit.
  assign attack_ready = (attack_cd < 6'd2);
  assign parry_ready  = (parry_cd < 6'd2);

  assign pose         = state;
  assign parry_active = (state == S_PARRY);
  assign busy         = (state == S_JUMP) || (state == S_ATTACK) || (state == S_PARRY);

  // Next-state evaluation for one frame tick. Free states (IDLE, WALK,
  // CROUCH) run the action priority list; timed states count down and
  // return to IDLE when their timer reaches 1.
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    x_n         = x_pos;
    facing_n    = facing_left;
    hit_n       = 1'b0;
    attack_cd_n = (state != S_ATTACK && attack_cd != 6'd0) ? attack_cd - 6'd1 : attack_cd;
    parry_cd_n  = (state != S_PARRY && parry_cd != 6'd0) ? parry_cd - 6'd1 : parry_cd;
    case (state)
      S_IDLE, S_WALK, S_CROUCH: begin
        if (cmd[6] && parry_ready) begin
          state_n = S_PARRY;
          timer_n = PARRY_T;
        end else if (cmd[5] && attack_ready) begin
          state_n = S_ATTACK;
          timer_n = ATTACK_T;
          hit_n   = 1'b1;
        end else if (go_up) begin
          state_n = S_JUMP;
          timer_n = JUMP_T;
        end else if (go_down) begin
          state_n = S_CROUCH;
        end else if (go_left) begin
          state_n  = S_WALK;
          x_n      = x_left;
          facing_n = 1'b1;
        end else if (go_right) begin
          state_n  = S_WALK;
          x_n      = x_right;
          facing_n = 1'b0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_JUMP: begin
        // Air control: horizontal input still steers, everything else ignored.
        if (go_left) begin
          x_n      = x_left;
          facing_n = 1'b1;
        end else if (go_right) begin
          x_n      = x_right;
          facing_n = 1'b0;
        end
        timer_n = timer - 6'd1;
        if (timer == 6'd1) state_n = S_IDLE;
      end
      S_ATTACK: begin
        timer_n = timer - 6'd1;
        if (timer == 6'd1) begin
          state_n     = S_IDLE;
          attack_cd_n = ATTACK_CD;
        end
      end
      S_PARRY: begin
        timer_n = timer - 6'd1;
        if (timer == 6'd1) begin
          state_n    = S_IDLE;
          parry_cd_n = PARRY_CD;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = 6'd0;
      end
    endcase
  end

  // attack_hit clears on every clock so it can never outlive one cycle;
  // all other state only moves on a frame tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= 6'd0;
      attack_cd   <= 6'd0;
      parry_cd    <= 6'd0;
      x_pos       <= X_START_X;
      facing_left <= 1'b0;
      attack_hit  <= 1'b0;
    end else begin
      attack_hit <= frame_tick && hit_n;
      if (frame_tick) begin
        state       <= state_n;
        timer       <= timer_n;
        attack_cd   <= attack_cd_n;
        parry_cd    <= parry_cd_n;
        x_pos       <= x_n;
        facing_left <= facing_n;
      end
    end
  end

endmodule
